// File: rtl/axi_write_arbiter.sv
// Write-path address decoder and per-slave round-robin arbiter for the AXI crossbar.
// Holds each master->slave pairing from AW grant through B completion and registers the mux routing indices.
module axi_write_arbiter #(
  parameter int NUM_M     = 3,
  parameter int NUM_S     = 6,
  parameter int MIDX_BITS = 2,
  parameter int SIDX_BITS = 3
) (
  input  logic                                ACLK,
  input  logic                                ARESET,
  input  logic [NUM_M-1:0][31:0]              AWADDR_M,
  input  logic [NUM_M-1:0]                    AWVALID_M,
  input  logic [NUM_S:0]                      AWREADY_S,
  input  logic [NUM_M-1:0]                    WVALID_M,
  input  logic [NUM_M-1:0]                    WLAST_M,
  input  logic [NUM_S:0]                      WREADY_S,
  input  logic [NUM_S:0]                      BVALID_S,
  input  logic [NUM_M-1:0]                    BREADY_M,
  output logic [NUM_S:0][MIDX_BITS-1:0]       SWIdx,
  output logic [NUM_M-1:0][SIDX_BITS-1:0]     MWIdx
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_AW = 2'd1, ST_W = 2'd2, ST_B = 2'd3} state_t;

  state_t                  state_r     [NUM_M];
  state_t                  state_nxt_s [NUM_M];
  logic [SIDX_BITS-1:0]    tgt_r       [NUM_M];
  logic [SIDX_BITS-1:0]    tgt_nxt_s   [NUM_M];
  logic [SIDX_BITS-1:0]    dec_s       [NUM_M];
  logic [NUM_M-1:0]        req_s;
  logic [NUM_M-1:0]        grant_s;
  logic [NUM_S:0]          busy_s;
  logic [MIDX_BITS-1:0]    rr_ptr_r;
  logic [MIDX_BITS-1:0]    ptr_nxt_s;
  logic [NUM_S:0][MIDX_BITS-1:0]   sw_nxt_s;
  logic [NUM_M-1:0][SIDX_BITS-1:0] mw_nxt_s;
  logic                    found_s;
  logic                    win_s;
  int                      idx_s;

  // Address map; unmapped addresses route to the default (decode-error) slave.
  function automatic logic [SIDX_BITS-1:0] decode(input logic [31:0] a);
    logic [SIDX_BITS-1:0] r;
    if (a <= 32'h0000_3FFF)                            r = SIDX_BITS'(0);
    else if (a >= 32'h0001_0000 && a <= 32'h0001_FFFF) r = SIDX_BITS'(1);
    else if (a >= 32'h0002_0000 && a <= 32'h0002_FFFF) r = SIDX_BITS'(2);
    else if (a >= 32'h1002_0000 && a <= 32'h1002_03FF) r = SIDX_BITS'(3);
    else if (a >= 32'h1001_0000 && a <= 32'h1001_03FF) r = SIDX_BITS'(4);
    else if (a >= 32'h2000_0000 && a <= 32'h201F_FFFF) r = SIDX_BITS'(5);
    else                                               r = SIDX_BITS'(NUM_S);
    return r;
  endfunction

  // Request decode, slave occupancy and round-robin arbitration.
  always_comb begin
    grant_s   = '0;
    busy_s    = '0;
    ptr_nxt_s = rr_ptr_r;
    found_s   = 1'b0;
    win_s     = 1'b0;
    idx_s     = 0;
    for (int m = 0; m < NUM_M; m++) begin
      req_s[m] = (state_r[m] == ST_IDLE) & AWVALID_M[m];
      dec_s[m] = decode(AWADDR_M[m]);
      for (int s = 0; s <= NUM_S; s++) begin
        busy_s[s] = busy_s[s] | ((state_r[m] != ST_IDLE) && (tgt_r[m] == SIDX_BITS'(s)));
      end
    end
    for (int s = 0; s <= NUM_S; s++) begin
      found_s = 1'b0;
      for (int k = 0; k < NUM_M; k++) begin
        idx_s = (int'(rr_ptr_r) + k) % NUM_M;
        win_s = ~found_s & ~busy_s[s] & req_s[idx_s] & (dec_s[idx_s] == SIDX_BITS'(s));
        grant_s[idx_s] = grant_s[idx_s] | win_s;
        found_s = found_s | win_s;
      end
    end
    // With grants on several slaves at once, the pointer follows the last winner in RR order.
    for (int k = 0; k < NUM_M; k++) begin
      idx_s = (int'(rr_ptr_r) + k) % NUM_M;
      ptr_nxt_s = grant_s[idx_s] ? MIDX_BITS'((idx_s + 1) % NUM_M) : ptr_nxt_s;
    end
  end

  // Per-master next state and held target.
  always_comb begin
    for (int m = 0; m < NUM_M; m++) begin
      tgt_nxt_s[m] = grant_s[m] ? dec_s[m] : tgt_r[m];
      case (state_r[m])
        ST_IDLE: state_nxt_s[m] = grant_s[m] ? ST_AW : ST_IDLE;
        ST_AW:   state_nxt_s[m] = (AWVALID_M[m] & AWREADY_S[tgt_r[m]]) ? ST_W : ST_AW;
        ST_W:    state_nxt_s[m] = (WVALID_M[m] & WREADY_S[tgt_r[m]] & WLAST_M[m]) ? ST_B : ST_W;
        ST_B:    state_nxt_s[m] = (BVALID_S[tgt_r[m]] & BREADY_M[m]) ? ST_IDLE : ST_B;
        default: state_nxt_s[m] = ST_IDLE;
      endcase
    end
  end

  // State, target and round-robin pointer registers.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rr_ptr_r <= '0;
      for (int m = 0; m < NUM_M; m++) begin
        state_r[m] <= ST_IDLE;
        tgt_r[m]   <= SIDX_BITS'(NUM_S + 1);
      end
    end else begin
      rr_ptr_r <= ptr_nxt_s;
      for (int m = 0; m < NUM_M; m++) begin
        state_r[m] <= state_nxt_s[m];
        tgt_r[m]   <= tgt_nxt_s[m];
      end
    end
  end

  // Routing indices derived from the upcoming ownership.
  always_comb begin
    for (int m = 0; m < NUM_M; m++) begin
      mw_nxt_s[m] = (state_nxt_s[m] != ST_IDLE) ? tgt_nxt_s[m] : SIDX_BITS'(NUM_S + 1);
    end
    for (int s = 0; s <= NUM_S; s++) begin
      sw_nxt_s[s] = MIDX_BITS'(NUM_M);
      for (int m = 0; m < NUM_M; m++) begin
        sw_nxt_s[s] = ((state_nxt_s[m] != ST_IDLE) && (tgt_nxt_s[m] == SIDX_BITS'(s)))
                      ? MIDX_BITS'(m) : sw_nxt_s[s];
      end
    end
  end

  // Registered routing outputs.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int s = 0; s <= NUM_S; s++) SWIdx[s] <= MIDX_BITS'(NUM_M);
      for (int m = 0; m < NUM_M; m++)  MWIdx[m] <= SIDX_BITS'(NUM_S + 1);
    end else begin
      SWIdx <= sw_nxt_s;
      MWIdx <= mw_nxt_s;
    end
  end

endmodule

// File: tb/tb_axi_write_arbiter.sv
// Directed bench for axi_write_arbiter: stimulus pushes per-cycle expectations into a
// scoreboard queue and an independent monitor compares them against the outputs.
module tb_axi_write_arbiter;
  localparam int NUM_M = 3;
  localparam int NUM_S = 6;
  localparam int MIDX_BITS = 2;
  localparam int SIDX_BITS = 3;
  localparam int M_NONE = NUM_M;
  localparam int S_NONE = NUM_S + 1;

  logic                            ACLK;
  logic                            ARESET;
  logic [NUM_M-1:0][31:0]          AWADDR_M;
  logic [NUM_M-1:0]                AWVALID_M;
  logic [NUM_S:0]                  AWREADY_S;
  logic [NUM_M-1:0]                WVALID_M;
  logic [NUM_M-1:0]                WLAST_M;
  logic [NUM_S:0]                  WREADY_S;
  logic [NUM_S:0]                  BVALID_S;
  logic [NUM_M-1:0]                BREADY_M;
  logic [NUM_S:0][MIDX_BITS-1:0]   SWIdx;
  logic [NUM_M-1:0][SIDX_BITS-1:0] MWIdx;

  axi_write_arbiter #(.NUM_M(NUM_M), .NUM_S(NUM_S), .MIDX_BITS(MIDX_BITS), .SIDX_BITS(SIDX_BITS)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .AWADDR_M(AWADDR_M), .AWVALID_M(AWVALID_M),
    .AWREADY_S(AWREADY_S), .WVALID_M(WVALID_M), .WLAST_M(WLAST_M), .WREADY_S(WREADY_S),
    .BVALID_S(BVALID_S), .BREADY_M(BREADY_M), .SWIdx(SWIdx), .MWIdx(MWIdx)
  );

  typedef struct {
    int    cyc;
    int    kind;   // 0 = SWIdx, 1 = MWIdx, 2 = round-robin pointer
    int    idx;
    int    val;
    string name;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;
  always @(posedge ACLK) cyc <= cyc + 1;

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic push(input int kind, input int idx, input int val, input string name);
    exp_t e;
    e.cyc = cyc; e.kind = kind; e.idx = idx; e.val = val; e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic push_all_idle(input string name);
    for (int s = 0; s <= NUM_S; s++) push(0, s, M_NONE, name);
    for (int m = 0; m < NUM_M; m++) push(1, m, S_NONE, name);
  endtask

  // Monitor: compares every expectation due in the current cycle.
  always @(negedge ACLK) begin
    exp_t e;
    int   act;
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      e = sb_q.pop_front();
      case (e.kind)
        0:       act = int'(SWIdx[e.idx]);
        1:       act = int'(MWIdx[e.idx]);
        default: act = int'(dut.rr_ptr_r);
      endcase
      n_checks++;
      if (act != e.val) begin
        n_fail++;
        $display("FAIL %s kind%0d[%0d]: actual %0d, required %0d (cycle %0d)",
                 e.name, e.kind, e.idx, act, e.val, cyc);
      end
    end
  end

  task automatic clear_masters();
    AWVALID_M = '0; WVALID_M = '0; WLAST_M = '0; BVALID_S = '0;
  endtask

  task automatic do_reset();
    ARESET = 1'b1;
    step();
    step();
    ARESET = 1'b0;
    clear_masters();
    push_all_idle("reset");
  endtask

  // Called in the cycle master m sits in AW (AWVALID[m] still high); finishes the burst.
  task automatic run_txn(input int m, input int s, input int beats, input string name);
    step();
    AWVALID_M[m] = 1'b0;
    for (int i = 0; i < beats; i++) begin
      WVALID_M[m] = 1'b1;
      WLAST_M[m]  = (i == beats - 1);
      push(1, m, s, {name, "_wbeat"});
      push(0, s, m, {name, "_wbeat"});
      step();
    end
    WVALID_M[m] = 1'b0;
    WLAST_M[m]  = 1'b0;
    BVALID_S[s] = 1'b1;
    push(1, m, s, {name, "_bwait"});
    step();
    BVALID_S[s] = 1'b0;
    push(1, m, S_NONE, {name, "_release"});
    push(0, s, M_NONE, {name, "_release"});
  endtask

  logic [31:0] dec_addr [11];
  int          dec_exp  [11];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    dec_addr = '{32'h0000_0000, 32'h0000_3FFF, 32'h0000_4000, 32'h0001_FFFF, 32'h0002_FFFF,
                 32'h1002_0000, 32'h1002_0400, 32'h1001_03FF, 32'h2000_0000, 32'h201F_FFFF,
                 32'h2020_0000};
    dec_exp  = '{0, 0, 6, 1, 2, 3, 6, 4, 5, 5, 6};

    // Reset with every master requesting and every slave responding.
    AWREADY_S = '1; WREADY_S = '1; BREADY_M = '1;
    AWADDR_M[0] = 32'h0001_0000; AWADDR_M[1] = 32'h0002_0000; AWADDR_M[2] = 32'h2000_0000;
    AWVALID_M = '1; WVALID_M = '1; WLAST_M = '1; BVALID_S = '1;
    do_reset();
    n_checks++;
    if (SWIdx[0] != MIDX_BITS'(M_NONE)) begin
      n_fail++;
      $display("FAIL direct_reset_sw0: actual %0d, required %0d", SWIdx[0], M_NONE);
    end
    n_checks++;
    if (MWIdx[2] != SIDX_BITS'(S_NONE)) begin
      n_fail++;
      $display("FAIL direct_reset_mw2: actual %0d, required %0d", MWIdx[2], S_NONE);
    end

    // Single-beat write M1 -> DM.
    AWADDR_M[1] = 32'h0002_0010; AWVALID_M[1] = 1'b1;
    step();
    push(1, 1, 2, "m1_dm_grant"); push(0, 2, 1, "m1_dm_grant");
    n_checks++;
    if (MWIdx[1] != SIDX_BITS'(2)) begin
      n_fail++;
      $display("FAIL direct_m1_dm_mw: actual %0d, required 2", MWIdx[1]);
    end
    n_checks++;
    if (SWIdx[2] != MIDX_BITS'(1)) begin
      n_fail++;
      $display("FAIL direct_m1_dm_sw: actual %0d, required 1", SWIdx[2]);
    end
    run_txn(1, 2, 1, "m1_dm");

    // M0 and M1 contend for IM with pointer at 0.
    do_reset();
    AWADDR_M[0] = 32'h0001_0000; AWADDR_M[1] = 32'h0001_0000;
    AWVALID_M[0] = 1'b1; AWVALID_M[1] = 1'b1;
    step();
    push(0, 1, 0, "contend_m0_win"); push(1, 0, 1, "contend_m0_win");
    push(1, 1, S_NONE, "contend_m1_wait"); push(2, 0, 1, "contend_ptr1");
    run_txn(0, 1, 1, "contend_m0");
    push(1, 1, S_NONE, "contend_m1_not_yet");
    step();
    push(0, 1, 1, "contend_m1_grant"); push(1, 1, 1, "contend_m1_grant");
    push(2, 0, 2, "contend_ptr2");
    run_txn(1, 1, 1, "contend_m1");

    // Different slaves granted in the same cycle.
    AWADDR_M[0] = 32'h0001_0004; AWADDR_M[1] = 32'h2000_0100;
    AWVALID_M[0] = 1'b1; AWVALID_M[1] = 1'b1;
    step();
    push(1, 0, 1, "parallel"); push(1, 1, 5, "parallel");
    push(0, 1, 0, "parallel"); push(0, 5, 1, "parallel");
    step();
    AWVALID_M = '0; WVALID_M = 3'b011; WLAST_M = 3'b011;
    step();
    WVALID_M = '0; WLAST_M = '0; BVALID_S[1] = 1'b1; BVALID_S[5] = 1'b1;
    step();
    BVALID_S = '0;
    push_all_idle("parallel_release");

    // Unmapped address -> default slave, 4-beat burst.
    AWADDR_M[1] = 32'h3000_0000; AWVALID_M[1] = 1'b1;
    step();
    push(1, 1, 6, "default_grant"); push(0, 6, 1, "default_grant");
    run_txn(1, 6, 4, "default_burst");

    // Decode boundaries through M2.
    for (int i = 0; i < 11; i++) begin
      AWADDR_M[2] = dec_addr[i]; AWVALID_M[2] = 1'b1;
      step();
      push(1, 2, dec_exp[i], "decode_grant"); push(0, dec_exp[i], 2, "decode_grant");
      run_txn(2, dec_exp[i], 1, "decode");
    end

    // Reset in the middle of a burst to DM.
    AWADDR_M[0] = 32'h0002_0000; AWVALID_M[0] = 1'b1;
    step();
    push(1, 0, 2, "abort_grant");
    step();
    AWVALID_M[0] = 1'b0; WVALID_M[0] = 1'b1; WLAST_M[0] = 1'b0;
    step();
    push(1, 0, 2, "abort_in_w");
    ARESET = 1'b1;
    step();
    ARESET = 1'b0;
    clear_masters();
    push(0, 2, M_NONE, "abort_sw"); push(1, 0, S_NONE, "abort_mw");
    n_checks++;
    if (SWIdx[2] != MIDX_BITS'(M_NONE)) begin
      n_fail++;
      $display("FAIL direct_abort_sw: actual %0d, required %0d", SWIdx[2], M_NONE);
    end
    AWADDR_M[1] = 32'h0002_0040; AWVALID_M[1] = 1'b1;
    step();
    push(1, 1, 2, "post_abort_grant"); push(0, 2, 1, "post_abort_grant");
    run_txn(1, 2, 1, "post_abort");

    step();
    step();
    while (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL %s: expectation never checked (cycle %0d)", e.name, e.cyc);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
